// File: rtl/vedic_mac_pkg.sv
// Shared types and constants for the vedic MAC accumulator slice.
package vedic_mac_pkg;

  localparam int unsigned PROD_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    HOLD
  } state_e;

endpackage

// File: rtl/vedic_mac_ctr.sv
// Beat counter for one accumulation frame: clear, load-to-one, increment,
// and a terminal-count flag meaning the next increment completes the frame.
module vedic_mac_ctr #(
  parameter int unsigned ACC_LEN = 4,
  parameter int unsigned CNT_W   = $clog2(ACC_LEN + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic load,
  input  logic inc,
  output logic tc
);

  localparam logic [CNT_W-1:0] LAST_M1 = CNT_W'(ACC_LEN - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = CNT_W'(1);
    end else if (inc) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == LAST_M1);

endmodule

// File: rtl/vedic_mac_acc.sv
// Frame accumulator for vedic8x8 products with valid/ready on both sides.
// Define VEDIC_MAC_SAT_EN to clamp on overflow instead of wrapping.
module vedic_mac_acc
  import vedic_mac_pkg::*;
#(
  parameter int unsigned ACC_W   = 24,
  parameter int unsigned ACC_LEN = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PROD_W-1:0] prod,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              acc_clr,
  output logic [ACC_W-1:0]  out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              ovf
);

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic [ACC_W:0]   sum;
  logic             accept;
  logic             ctr_clr, ctr_load, ctr_inc, ctr_tc;

  vedic_mac_ctr #(
    .ACC_LEN(ACC_LEN)
  ) u_ctr (
    .clk  (clk),
    .rst  (rst),
    .clr  (ctr_clr),
    .load (ctr_load),
    .inc  (ctr_inc),
    .tc   (ctr_tc)
  );

  assign in_ready  = (state_q != HOLD);
  assign out_valid = (state_q == HOLD);
  assign out_data  = acc_q;
  assign ovf       = ovf_q;
  assign accept    = in_valid && in_ready;
  assign sum       = {1'b0, acc_q} + (ACC_W + 1)'(prod);

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    ovf_d    = ovf_q;
    ctr_clr  = 1'b0;
    ctr_load = 1'b0;
    ctr_inc  = 1'b0;
    // Abort outranks both the input accept and the output handshake.
    if (acc_clr) begin
      state_d = IDLE;
      acc_d   = '0;
      ovf_d   = 1'b0;
      ctr_clr = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            acc_d    = ACC_W'(prod);
            ovf_d    = 1'b0;
            ctr_load = 1'b1;
            state_d  = (ACC_LEN == 1) ? HOLD : ACCUM;
          end
        end
        ACCUM: begin
          if (accept) begin
            ovf_d   = ovf_q | sum[ACC_W];
            ctr_inc = 1'b1;
`ifdef VEDIC_MAC_SAT_EN
            acc_d = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
`else
            acc_d = sum[ACC_W-1:0];
`endif
            if (ctr_tc) begin
              state_d = HOLD;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule
